// File: rtl/bird_game_pkg.sv
// bird_game_pkg: shared screen geometry, fixed-point scale and plane FSM states
package bird_game_pkg;
  localparam int FIXED_POINT_MULTIPLIER = 64;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  typedef enum logic [2:0] {IDLE_ST, FLY_ST, ARMED_ST, WAIT_HIDE_ST, OUT_ST} plane_st_t;
endpackage

// File: rtl/key_edge_detect.sv
// key_edge_detect: two-flop synchroniser followed by a one-clock rising-edge pulse
module key_edge_detect (
  input  logic clk,
  input  logic resetN,
  input  logic i_key,
  output logic o_rise
);
  logic [2:0] r_sync;
  // shift the raw key through two sync flops plus one history flop
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) r_sync <= '0;
    else r_sync <= {r_sync[1:0], i_key};
  assign o_rise = r_sync[1] & ~r_sync[2];
endmodule

// File: rtl/plane_launcher.sv
// plane_launcher: flies the plane across the screen, holds launch speed and arms bird launches.
// Optional build macro PLANE_BOB_EN adds a 0..7 pixel triangle-wave bob to the plane Y.
module plane_launcher
  import bird_game_pkg::*;
#(
  parameter int PLANE_Y         = 40,
  parameter int PLANE_X_SPEED   = 96,
  parameter int PLANE_WIDTH     = 64,
  parameter int LAUNCH_X_MAX    = 287,
  parameter int SPEED_INIT      = 40,
  parameter int SPEED_MIN       = 8,
  parameter int SPEED_MAX       = 120,
  parameter int SPEED_STEP      = 8,
  parameter int BIRDS_PER_ROUND = 5
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               i_startOfFrame,
  input  logic               i_keyLaunch,
  input  logic               i_keySpeedUp,
  input  logic               i_keySpeedDown,
  input  logic               i_birdDisplayed,
  input  logic               i_hideBirdPulse,
  input  logic               i_newRound,
  output logic signed [10:0] o_planeTopLeftX,
  output logic signed [10:0] o_planeTopLeftY,
  output logic        [10:0] o_planeVertSpeed,
  output logic               o_showBird,
  output logic        [3:0]  o_birdsLeft,
  output logic               o_outOfBirds
);
  localparam logic signed [16:0] X_RESET = 17'(-(PLANE_WIDTH * FIXED_POINT_MULTIPLIER));
  localparam logic signed [16:0] X_WRAP  = 17'((SCREEN_W - 1) * FIXED_POINT_MULTIPLIER);
  localparam logic signed [16:0] X_STEP  = 17'(PLANE_X_SPEED);
  localparam logic signed [10:0] X_MAX   = 11'(LAUNCH_X_MAX);
  localparam logic signed [10:0] Y_BASE  = 11'(PLANE_Y);
  localparam logic [10:0] S_INIT = 11'(SPEED_INIT);
  localparam logic [10:0] S_MIN  = 11'(SPEED_MIN);
  localparam logic [10:0] S_MAX  = 11'(SPEED_MAX);
  localparam logic [10:0] S_STEP = 11'(SPEED_STEP);
  localparam logic [3:0]  B_INIT = 4'(BIRDS_PER_ROUND);

  plane_st_t          r_state;
  logic signed [16:0] r_xpos;
  logic signed [16:0] w_xstep;
  logic signed [10:0] w_xpix;
  logic        [10:0] r_speed;
  logic        [10:0] w_speed_up;
  logic        [10:0] w_speed_dn;
  logic        [10:0] w_speed_nx;
  logic        [3:0]  r_birds;
  logic               r_show;
  logic               r_up;
  logic               r_dn;
  logic               r_launch;
  logic               w_up_rise;
  logic               w_dn_rise;
  logic               w_launch_rise;
  logic               w_in_window;

  key_edge_detect u_up     (.clk(clk), .resetN(resetN), .i_key(i_keySpeedUp),   .o_rise(w_up_rise));
  key_edge_detect u_dn     (.clk(clk), .resetN(resetN), .i_key(i_keySpeedDown), .o_rise(w_dn_rise));
  key_edge_detect u_launch (.clk(clk), .resetN(resetN), .i_key(i_keyLaunch),    .o_rise(w_launch_rise));

  assign w_xstep     = r_xpos + X_STEP;
  assign w_xpix      = r_xpos[16:6];
  assign w_in_window = w_xpix <= X_MAX;
  assign w_speed_up  = (r_speed >= S_MAX - S_STEP) ? S_MAX : r_speed + S_STEP;
  assign w_speed_dn  = (r_speed <= S_MIN + S_STEP) ? S_MIN : r_speed - S_STEP;
  assign w_speed_nx  = (r_up & ~r_dn) ? w_speed_up : (r_dn & ~r_up) ? w_speed_dn : r_speed;

  // sticky key latches: set by an edge, consumed and cleared by the next frame start
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) {r_up, r_dn, r_launch} <= '0;
    else if (i_startOfFrame) {r_up, r_dn, r_launch} <= '0;
    else {r_up, r_dn, r_launch} <= {r_up | w_up_rise, r_dn | w_dn_rise, r_launch | w_launch_rise};

  // plane X in 1/64 pixel, stepping once per frame once flight has started and wrapping off the right edge
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) r_xpos <= X_RESET;
    else if (i_startOfFrame && r_state != IDLE_ST) r_xpos <= (w_xstep > X_WRAP) ? X_RESET : w_xstep;

  // launch FSM: newRound overrides everything, a bird display beats a same-clock frame abort
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      r_state <= IDLE_ST;
      r_speed <= S_INIT;
      r_birds <= B_INIT;
      r_show  <= 1'b0;
    end else if (i_newRound) begin
      r_state <= FLY_ST;
      r_speed <= S_INIT;
      r_birds <= B_INIT;
      r_show  <= 1'b0;
    end else begin
      case (r_state)
        IDLE_ST: if (i_startOfFrame) r_state <= FLY_ST;
        FLY_ST: if (i_startOfFrame) begin
          r_speed <= w_speed_nx;
          if (r_launch && w_in_window && r_birds != 4'd0) begin
            r_state <= ARMED_ST;
            r_show  <= 1'b1;
          end
        end
        ARMED_ST: if (i_birdDisplayed) begin
          r_state <= WAIT_HIDE_ST;
          r_show  <= 1'b0;
          r_birds <= (r_birds != 4'd0) ? r_birds - 4'd1 : r_birds;
        end else if (i_startOfFrame && !w_in_window) begin
          r_state <= FLY_ST;
          r_show  <= 1'b0;
        end
        WAIT_HIDE_ST: if (i_hideBirdPulse) r_state <= (r_birds != 4'd0) ? FLY_ST : OUT_ST;
        default: ;
      endcase
    end

`ifdef PLANE_BOB_EN
  logic [2:0] r_bob;
  logic [1:0] r_bob_cnt;
  logic       r_bob_dir;
  logic       w_bob_up;
  assign w_bob_up = r_bob_dir ? (r_bob != 3'd7) : (r_bob == 3'd0);
  // triangle-wave bob moving one pixel every fourth frame, reversing at 0 and 7
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      r_bob     <= '0;
      r_bob_cnt <= '0;
      r_bob_dir <= 1'b1;
    end else if (i_startOfFrame) begin
      r_bob_cnt <= r_bob_cnt + 2'd1;
      if (r_bob_cnt == 2'd3) begin
        r_bob     <= w_bob_up ? r_bob + 3'd1 : r_bob - 3'd1;
        r_bob_dir <= w_bob_up;
      end
    end
  assign o_planeTopLeftY = Y_BASE + {8'd0, r_bob};
`else
  assign o_planeTopLeftY = Y_BASE;
`endif

  assign o_planeTopLeftX  = w_xpix;
  assign o_planeVertSpeed = r_speed;
  assign o_showBird       = r_show;
  assign o_birdsLeft      = r_birds;
  assign o_outOfBirds     = r_state == OUT_ST;
endmodule
